// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader: FSM states and counter widths.
package boot_pkg;

  // Loader phases: length field, data words, checksum byte, then a terminal state.
  typedef enum logic [2:0] {
    LEN   = 3'd0,
    DATA  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  // Byte position inside a 32-bit word.
  localparam int IDX_W = 2;

  // Default image limit and the matching word-counter width.
  localparam int DEFAULT_MAX_WORDS = 1024;
  localparam int DEFAULT_WCNT_W    = $clog2(DEFAULT_MAX_WORDS + 1);

  // Word counter must hold values 0..max_words inclusive.
  function automatic int word_cnt_width(input int max_words);
    return $clog2(max_words + 1);
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into little-endian 32-bit words. The assembled word is
// presented combinationally on the edge that accepts the 4th byte, so the
// consumer can capture it on that same edge.
module byte_packer
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        accept,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [IDX_W-1:0] idx_reg;
  logic [IDX_W-1:0] idx_next;

  // Byte index advances on each accepted byte and wraps after the 4th.
  always_comb begin
    idx_next = idx_reg;
    if (accept) begin
      idx_next = idx_reg + IDX_W'(1);
    end
  end

  // Byte index register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_reg <= '0;
    end else begin
      idx_reg <= idx_next;
    end
  end

  assign word_valid = accept && (idx_reg == '1);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_reg;
      logic       lane_hit;

      assign lane_hit = accept && (idx_reg == IDX_W'(gi));

      // Lane gi captures byte gi of the current word.
      always_ff @(posedge clk) begin
        if (!reset) begin
          lane_reg <= '0;
        end else if (lane_hit) begin
          lane_reg <= byte_in;
        end
      end

      // Bypass the incoming byte so the full word is visible on its last byte.
      assign word[8*gi +: 8] = lane_hit ? byte_in : lane_reg;
    end
  endgenerate

endmodule

// File: rtl/boot_loader.sv
// Framed program loader: length, little-endian data words written sequentially
// to memory, XOR checksum. Keeps the core in reset until the image verifies.
module boot_loader
  import boot_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MAX_WORDS  = DEFAULT_MAX_WORDS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_wr,
  output logic                  core_reset,
  output logic                  done,
  output logic                  error
);

  localparam int WCNT_W = word_cnt_width(MAX_WORDS);

  state_t                state_reg, state_next;
  logic [WCNT_W-1:0]     len_reg, len_next;
  logic [WCNT_W-1:0]     wcnt_reg, wcnt_next;
  logic [7:0]            csum_reg, csum_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [31:0]           wdata_reg, wdata_next;
  logic                  wr_reg, wr_next;

  logic                  byte_acc;
  logic                  pk_accept;
  logic [31:0]           pk_word;
  logic                  pk_valid;

  // Ready depends only on registered state so it never loops through in_valid.
  assign in_ready  = (state_reg == LEN) || (state_reg == CHECK) ||
                     ((state_reg == DATA) && !wr_reg);
  assign byte_acc  = in_valid && in_ready;
  // The checksum byte bypasses the packer; only length and data bytes are packed.
  assign pk_accept = byte_acc && ((state_reg == LEN) || (state_reg == DATA));

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (in_data),
    .accept     (pk_accept),
    .word       (pk_word),
    .word_valid (pk_valid)
  );

  // Next-state logic for the FSM, counters, checksum and write port.
  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    wcnt_next  = wcnt_reg;
    csum_next  = csum_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    wr_next    = 1'b0;

    case (state_reg)
      LEN: begin
        if (pk_valid) begin
          if (pk_word > 32'(MAX_WORDS)) begin
            state_next = ERROR;
          end else if (pk_word == '0) begin
            state_next = CHECK;
          end else begin
            len_next   = pk_word[WCNT_W-1:0];
            state_next = DATA;
          end
        end
      end

      DATA: begin
        if (wr_reg) begin
          // Write cycle: step the address and count the word just written.
          addr_next = addr_reg + ADDR_WIDTH'(4);
          wcnt_next = wcnt_reg + WCNT_W'(1);
          if ((wcnt_reg + WCNT_W'(1)) == len_reg) begin
            state_next = CHECK;
          end
        end else if (byte_acc) begin
          csum_next = csum_reg ^ in_data;
          if (pk_valid) begin
            wdata_next = pk_word;
            wr_next    = 1'b1;
          end
        end
      end

      CHECK: begin
        if (byte_acc) begin
          state_next = (in_data == csum_reg) ? DONE : ERROR;
        end
      end

      default: begin
        // DONE and ERROR are held until reset.
      end
    endcase
  end

  // State and datapath registers; active-low reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= LEN;
      len_reg   <= '0;
      wcnt_reg  <= '0;
      csum_reg  <= '0;
      addr_reg  <= BASE_ADDR;
      wdata_reg <= '0;
      wr_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      wcnt_reg  <= wcnt_next;
      csum_reg  <= csum_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      wr_reg    <= wr_next;
    end
  end

  assign mem_addr   = addr_reg;
  assign mem_wdata  = wdata_reg;
  assign mem_wr     = wr_reg;
  assign done       = (state_reg == DONE);
  assign error      = (state_reg == ERROR);
  assign core_reset = (state_reg != DONE);

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: a frame-level model derived from the
// byte history, checked every cycle, plus directed literal expectations.
module tb_boot_loader;

  localparam int          MAXW = 1024;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        core_reset;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  boot_loader #(
    .ADDR_WIDTH (32),
    .BASE_ADDR  (BASE),
    .MAX_WORDS  (MAXW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wr     (mem_wr),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  q[$];        // bytes accepted in the current frame
  int          words = 0;   // complete data words accepted
  logic [31:0] last_word = '0;
  bit          wr_exp = 0;  // a word completed on the previous edge
  bit          mv = 0;      // model valid (a reset has been seen)
  logic [63:0] wlog[$];     // observed writes {addr, data}

  // 0 = frame in progress, 1 = done, 2 = error
  function automatic int status();
    int n;
    logic [31:0] nw;
    logic [7:0] x;
    n = q.size();
    if (n < 4) return 0;
    nw = {q[3], q[2], q[1], q[0]};
    if (nw > MAXW) return 2;
    if (n < 4 + 4 * int'(nw) + 1) return 0;
    x = 8'h00;
    for (int i = 4; i < n - 1; i++) x ^= q[i];
    return (q[n-1] == x) ? 1 : 2;
  endfunction

  function automatic void model_accept(input logic [7:0] b);
    int n;
    logic [31:0] nw;
    q.push_back(b);
    n = q.size();
    if (n > 4) begin
      nw = {q[3], q[2], q[1], q[0]};
      if (nw <= MAXW && n <= 4 + 4 * int'(nw) && ((n - 4) % 4) == 0) begin
        last_word = {q[n-1], q[n-2], q[n-3], q[n-4]};
        words++;
        wr_exp = 1;
      end
    end
  endfunction

  // Compare every cycle on the falling edge, then advance the model.
  always @(negedge clk) begin
    int st;
    if (mv) begin
      st = status();
      chk("in_ready", 64'(in_ready), 64'((st == 0) && !wr_exp));
      chk("mem_wr", 64'(mem_wr), 64'(wr_exp));
      chk("done", 64'(done), 64'(st == 1));
      chk("error", 64'(error), 64'(st == 2));
      chk("core_reset", 64'(core_reset), 64'(st != 1));
      chk("mem_addr", 64'(mem_addr), 64'(BASE + 32'(4 * words) - (wr_exp ? 32'd4 : 32'd0)));
      chk("mem_wdata", 64'(mem_wdata), 64'(last_word));
    end
    if (mem_wr === 1'b1) begin
      wlog.push_back({mem_addr, mem_wdata});
      $display("write addr=%08h data=%08h", mem_addr, mem_wdata);
    end
    if (!reset) begin
      q.delete();
      words = 0;
      last_word = '0;
      wr_exp = 0;
      mv = 1;
    end else if (mv) begin
      wr_exp = 0;
      if (in_valid && in_ready) model_accept(in_data);
    end
  end

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    bit   ok;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) ok = 1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout actual=not_accepted required=accepted byte=%02h", b);
    end
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input int max_gap);
    foreach (bytes[i]) send_byte(bytes[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] fr[$];
    logic [31:0] nw;
    logic [7:0] cs;
    bit good;

    do_reset();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_core_reset", 64'(core_reset), 64'd1);
    chk("rst_done_err", 64'({done, error, mem_wr}), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'(BASE));
    chk("rst_wdata", 64'(mem_wdata), 64'd0);

    // N=2 image, checksum 0x88
    wlog.delete();
    fr = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
           8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    send_frame(fr, 0);
    chk("n2_done", 64'({done, core_reset, error}), 64'b100);
    chk("n2_wcount", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      chk("n2_w0", wlog[0], {32'h0, 32'h44332211});
      chk("n2_w1", wlog[1], {32'h4, 32'h88776655});
    end
    idle(2);
    $display("frame N=2 done=%0b error=%0b", done, error);

    // N=0, checksum 0x00
    do_reset();
    wlog.delete();
    fr = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(fr, 0);
    chk("n0_done", 64'(done), 64'd1);
    idle(2);
    chk("n0_nowrite", 64'(wlog.size()), 64'd0);
    $display("frame N=0 done=%0b error=%0b", done, error);

    // N=1, bad checksum
    do_reset();
    wlog.delete();
    fr = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
    send_frame(fr, 0);
    chk("bad_cs_state", 64'({error, core_reset, done, in_ready}), 64'b1100);
    chk("bad_cs_wcount", 64'(wlog.size()), 64'd1);
    if (wlog.size() == 1) chk("bad_cs_w0", wlog[0], {32'h0, 32'hEFBEADDE});
    idle(2);
    $display("frame bad-checksum done=%0b error=%0b", done, error);

    // Length MAX_WORDS+1
    do_reset();
    wlog.delete();
    fr = '{8'h01, 8'h04, 8'h00, 8'h00};
    send_frame(fr, 0);
    chk("len_err", 64'({error, done, in_ready}), 64'b100);
    idle(4);
    chk("len_err_nowrite", 64'(wlog.size()), 64'd0);
    $display("frame len=1025 done=%0b error=%0b", done, error);

    // N=1 with in_valid toggling between bytes (checksum DE^AD^BE^EF = 0x22)
    do_reset();
    wlog.delete();
    fr = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    foreach (fr[i]) send_byte(fr[i], 1);
    chk("gap_done", 64'({done, error}), 64'b10);
    chk("gap_wcount", 64'(wlog.size()), 64'd1);
    if (wlog.size() == 1) chk("gap_w0", wlog[0], {32'h0, 32'hEFBEADDE});
    $display("frame gapped done=%0b error=%0b", done, error);

    // Reset after two data bytes, then a fresh frame
    do_reset();
    fr = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
    send_frame(fr, 0);
    do_reset();
    wlog.delete();
    fr = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    send_frame(fr, 0);
    chk("abort_done", 64'({done, error}), 64'b10);
    chk("abort_wcount", 64'(wlog.size()), 64'd1);
    if (wlog.size() == 1) chk("abort_w0", wlog[0], {32'h0, 32'h04030201});
    $display("frame after-abort done=%0b error=%0b", done, error);

    // Randomized frames
    for (int f = 0; f < 16; f++) begin
      do_reset();
      fr.delete();
      if ($urandom_range(0, 9) == 0) nw = 32'd1025 + 32'($urandom_range(0, 5000));
      else nw = 32'($urandom_range(0, 5));
      for (int i = 0; i < 4; i++) fr.push_back(nw[8*i +: 8]);
      cs = 8'h00;
      good = (nw <= MAXW);
      if (good) begin
        for (int i = 0; i < 4 * int'(nw); i++) begin
          logic [7:0] b;
          b = 8'($urandom_range(0, 255));
          cs ^= b;
          fr.push_back(b);
        end
        if ($urandom_range(0, 3) == 0) begin
          cs ^= 8'h5A;
          good = 0;
        end
        fr.push_back(cs);
      end
      send_frame(fr, 2);
      idle(2);
      chk("rand_done", 64'({done, error}), good ? 64'b10 : 64'b01);
      $display("frame rand %0d N=%0d done=%0b error=%0b", f, nw, done, error);
    end

    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
